serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//   Bit-serial N-bit adder: one full_adder_na cell is reused over WIDTH cycles.
//   The controller latches the operands and feeds the cell LSB-first,
//   recirculating the carry. It collects the sum bits and signals completion.
//   Sits between the operand source and the single shared full-adder cell.
//   Trades latency for area versus a ripple array.
// PARAMETERS
//   WIDTH   8   operand/sum width in bits, legal range 2..32
//   CNT_W   5   bit-counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk     in   1       single clock; all state updates on the rising edge
//   rst     in   1       synchronous, active-high reset
//   start   in   1       request to add; sampled only in IDLE
//   a       in   WIDTH   operand A, captured on the accepted start
//   b       in   WIDTH   operand B, captured on the accepted start
//   cin     in   1       carry-in, captured on the accepted start
//   busy    out  1       high while in RUN
//   done    out  1       one-cycle pulse; sum/cout are valid from this cycle on
//   sum     out  WIDTH   result, a+b+cin modulo 2**WIDTH
//   cout    out  1       carry out of the MSB
// BEHAVIOUR
//   Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, sum=0, cout=0.
//     All shift registers, the carry and the counter are cleared.
//   FSM states: IDLE, RUN, DONE.
//     IDLE -> RUN on start=1. Same edge: a_sr<=a, b_sr<=b, carry<=cin,
//       cnt<=0, sum_sr<=0.
//     RUN: each edge drives the full_adder_na cell with (a_sr[0], b_sr[0], carry).
//       a_sr and b_sr shift right by 1.
//       The cell's sum bit enters sum_sr at the MSB; sum_sr shifts right.
//       carry <= cell cout; cnt <= cnt+1.
//     RUN -> DONE on the edge where cnt==WIDTH-1, i.e. after exactly WIDTH RUN edges.
//     DONE -> IDLE unconditionally after one cycle.
//   Latency: start sampled at edge E0, done=1 during the cycle after edge E0+WIDTH.
//     The next start can be accepted at E0+WIDTH+2 at the earliest.
//   Outputs:
//     busy = (state==RUN); done = (state==DONE); both registered.
//     sum/cout update only on the RUN->DONE edge.
//     They then hold their value until the next accepted start completes.
//     Intermediate bits are never exposed.
//   start is level-sampled in IDLE only.
//     start during RUN or DONE is ignored and dropped, not queued.
//     start held high continuously gives back-to-back operations, one every WIDTH+2 cycles.
//   Operands a/b/cin may change freely after the accepting edge and do not affect the result.
//   rst mid-RUN aborts the add: back to IDLE, sum/cout cleared, no done pulse.
//   rst has priority over start when both are high at the same edge.
//   Wrap-around: the sum is truncated to WIDTH bits; the overflowing carry appears only on cout.
//   cnt never exceeds WIDTH-1.
// CONFIGURATION
//   Macro SERIAL_ADD_OVF_EN:
//     defined: adds output port ovf (1 bit) = two's-complement overflow,
//       i.e. carry into MSB XOR carry out of MSB.
//       Carry-in to the MSB is captured during the last RUN cycle.
//       ovf has the same reset value (0), update edge and hold rules as cout.
//     undefined: no ovf port and no extra register; all other behaviour is identical.
// TESTING
//   1. rst=1 for 2 cycles, then 0 -> busy=0, done=0, sum=0, cout=0; start=0 keeps IDLE.
//   2. WIDTH=8, a=8'h00, b=8'h00, cin=1, start 1 cycle -> done exactly 8 cycles after
//      the start edge, sum=8'h01, cout=0.
//   3. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
//      With SERIAL_ADD_OVF_EN: ovf=0.
//      Also a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
//   4. Exhaustive 3-bit sweep with WIDTH=2 (a,b in 0..3, cin 0/1) -> every {cout,sum}
//      equals a+b+cin; the bench compares against a reference model.
//   5. Pulse start again 3 cycles into RUN with different operands -> ignored;
//      the result matches the first operands, with a single done pulse.
//   6. Assert rst 4 cycles into RUN -> next cycle busy=0, no done pulse, sum=0;
//      a fresh start afterwards completes correctly.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full-adder cell is reused LSB-first over WIDTH cycles.
// Optional macro SERIAL_ADD_OVF_EN adds a registered two's-complement overflow output (ovf).

module full_adder_na (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  , output logic           ovf
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t state_q, state_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic carry_q, carry_d;
  logic cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic fa_s, fa_co;
  logic last_bit;

  full_adder_na u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so busy/done come straight from flops
  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sr_d = '0;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
        carry_d  = fa_co;
        // Results are published only once the MSB is done; cnt stops at WIDTH-1
        if (last_bit) begin
          sum_d  = {fa_s, sum_sr_q[WIDTH-1:1]};
          cout_d = fa_co;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d  = carry_q ^ fa_co;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8 instance plus a WIDTH=2 instance).
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       cin2 = 1'b0;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  int checks = 0;
  int errors = 0;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf, ovf2;
`endif

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_adder_ctrl #(.WIDTH(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is 1 time unit after an edge with the DUT idle.
  task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                         input logic [7:0] es, input logic ec, input logic eo, input string tag);
    int k;
    bit seen;
    a = ta; b = tb_; cin = tc; start = 1'b1;
    tick();
    start = 1'b0; a = ~ta; b = ~tb_; cin = ~tc;
    k = 0; seen = 0;
    while (!seen && k < 20) begin
      tick();
      k++;
      if (k == 1) chk({tag, "_busy"}, busy, 1'b1);
      if (done) seen = 1;
    end
    chk({tag, "_latency"}, k, 8);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("unused");
`endif
    tick();
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_sum_hold"}, sum, es);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int ndone;
    bit seen;
    logic [7:0] s_at_done;

    // 1. reset
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", cout, 1'b0);
    chk("rst_sum2", {cout2, sum2}, 3'b000);
    tick(); tick();
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);

    // 2./3. directed adds
    run_add(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, "cin_only");
    run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "wrap");
    run_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "ovf_pos");
    run_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "ovf_neg");

    // 4. exhaustive WIDTH=2 sweep
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          a2 = ia[1:0]; b2 = ib[1:0]; cin2 = ic[0]; start2 = 1'b1;
          tick();
          start2 = 1'b0;
          k = 0; seen = 0;
          while (!seen && k < 6) begin
            tick();
            k++;
            if (done2) seen = 1;
          end
          chk($sformatf("w2_lat_%0d_%0d_%0d", ia, ib, ic), k, 2);
          chk($sformatf("w2_sum_%0d_%0d_%0d", ia, ib, ic), {cout2, sum2}, ia + ib + ic);
          tick();
        end
      end
    end

    // 5. start during RUN is dropped
    a = 8'h3C; b = 8'h0F; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0; s_at_done = 8'hxx;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1; end
      if (i == 4) start = 1'b0;
      if (done) begin ndone++; s_at_done = sum; end
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_sum", s_at_done, 8'h4B);
    chk("ign_cout", cout, 1'b0);

    // 6. reset mid-RUN
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_sum", sum, 8'h00);
    chk("abort_cout", cout, 1'b0);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_add(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0, "after_abort");

    // start held high: one operation every WIDTH+2 cycles
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    k = 0;
    while (!done && k < 20) begin tick(); k++; end
    k = 0; seen = 0;
    while (!seen && k < 20) begin
      tick();
      k++;
      if (done) seen = 1;
    end
    start = 1'b0;
    chk("b2b_period", k, 10);
    chk("b2b_sum", sum, 8'h03);
    tick(); tick(); tick();
    chk("b2b_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
